uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART transmitter between `N_REQ` byte-stream requesters, such as the case-converted echo FIFO and a status/message generator. A winning requester holds the transmitter for a whole line: the lock releases on an end-of-line byte, on a burst limit, or on a stall timeout. This prevents interleaving of characters from different sources. The block sits between the requesters' ready/valid byte outputs and the `uart_tx` `i_data`/`i_valid`/`o_ready` port.

---
 rtl/uart_tx_arbiter.sv | 130 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_arbiter - line-locked round-robin sharing of one UART transmitter  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter int         N_REQ        = 2,
  parameter int         MAX_BURST    = 16,
  parameter int         HOLD_TIMEOUT = 255,
  parameter logic [7:0] EOL          = 8'h0A
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(HOLD_TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_RST   = IW'(N_REQ - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    last;
  logic [IW-1:0]    pick;
  logic [N_REQ-1:0] pick_oh;
  logic             found;
  logic [BW-1:0]    burst_cnt;
  logic [SW-1:0]    stall_cnt;
  logic             xfer;
  logic             release_now;
  logic [7:0]       req_byte [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_bytes
      assign req_byte[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  // Passthrough is gated by the registered state so an async reset silences it at once.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    req_ready = '0;
    if (state == LOCKED) begin
      tx_valid         = req_valid[owner];
      tx_data          = req_byte[owner];
      req_ready[owner] = tx_ready;
    end
  end

  always_comb begin
    int cand;
    cand    = 0;
    pick    = last;
    pick_oh = '0;
    found   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(last) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && req_valid[cand[IW-1:0]]) begin
        found                 = 1'b1;
        pick                  = cand[IW-1:0];
        pick_oh               = '0;
        pick_oh[cand[IW-1:0]] = 1'b1;
      end
    end
  end

  assign xfer = tx_valid && tx_ready;

  // EOL and burst-limit coincide on one transfer and release only once.
  assign release_now = (xfer && ((tx_data == EOL) || (burst_cnt == BURST_LAST)))
                    || (!req_valid[owner] && (stall_cnt == STALL_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      last      <= LAST_RST;
      burst_cnt <= '0;
      stall_cnt <= '0;
      grant     <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state     <= LOCKED;
            owner     <= pick;
            grant     <= pick_oh;
            busy      <= 1'b1;
            burst_cnt <= '0;
            stall_cnt <= '0;
          end
        end
        LOCKED: begin
          if (xfer) burst_cnt <= burst_cnt + BW'(1);
          // Backpressure keeps valid high, so it never advances the stall count.
          if (req_valid[owner]) stall_cnt <= '0;
          else                  stall_cnt <= stall_cnt + SW'(1);
          if (release_now) begin
            state <= IDLE;
            last  <= owner;
            grant <= '0;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// tb_uart_tx_arbiter - directed bench: N_REQ=2, MAX_BURST=4, HOLD_TIMEOUT=8.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  grant;
  logic        busy;

  uart_tx_arbiter #(
    .N_REQ(2), .MAX_BURST(4), .HOLD_TIMEOUT(8), .EOL(8'h0A)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] g;
    logic [7:0] d;
  } xfer_t;

  xfer_t      xlog[$];
  xfer_t      xexp[$];
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       en0, en1;
  logic [1:0] gh [0:4095];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         viol  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    req_valid[0]  = en0 && (q0.size() > 0);
    req_valid[1]  = en1 && (q1.size() > 0);
    req_data[7:0] = (q0.size() > 0) ? q0[0] : 8'h00;
    req_data[15:8] = (q1.size() > 0) ? q1[0] : 8'h00;
  endtask

  // One clock: snapshot at the falling edge, pop accepted bytes just after the rising edge.
  task automatic tick();
    logic [1:0] rr;
    logic [1:0] rv;
    xfer_t      e;
    @(negedge clk);
    rr = req_ready;
    rv = req_valid;
    if (cyc < 4096) gh[cyc] = grant;
    if ((req_ready & ~grant) != 2'b00) viol++;
    if (tx_valid && tx_ready) begin
      e.cyc = cyc; e.g = grant; e.d = tx_data;
      xlog.push_back(e);
    end
    @(posedge clk);
    #1;
    if (rr[0] && rv[0] && q0.size() > 0) void'(q0.pop_front());
    if (rr[1] && rv[1] && q1.size() > 0) void'(q1.pop_front());
    cyc++;
    refresh();
  endtask

  task automatic ex(input int c, input logic [1:0] g, input logic [7:0] d);
    xfer_t e;
    e.cyc = c; e.g = g; e.d = d;
    xexp.push_back(e);
  endtask

  task automatic check_log(input string tag);
    check($sformatf("%s count", tag), xlog.size(), xexp.size());
    for (int i = 0; i < xexp.size(); i++) begin
      if (i < xlog.size()) begin
        check($sformatf("%s[%0d] cycle", tag, i), xlog[i].cyc, xexp[i].cyc);
        check($sformatf("%s[%0d] owner", tag, i), xlog[i].g, xexp[i].g);
        check($sformatf("%s[%0d] data", tag, i), xlog[i].d, xexp[i].d);
      end
    end
    xlog.delete();
    xexp.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int errs;
    rst_n = 1'b0; tx_ready = 1'b0; en0 = 1'b0; en1 = 1'b0;
    refresh();
    tick(); tick();
    #1;
    check("rst grant", grant, 2'b00);
    check("rst busy", busy, 1'b0);
    check("rst tx_valid", tx_valid, 1'b0);
    check("rst req_ready", req_ready, 2'b00);
    check("rst tx_data", tx_data, 8'h00);
    tick();
    rst_n = 1'b1;

    // Single line from requester 0.
    q0.push_back(8'h48); q0.push_back(8'h49); q0.push_back(8'h0A);
    en0 = 1'b1; tx_ready = 1'b1; refresh();
    t0 = cyc;
    #1;
    check("t1 idle grant", grant, 2'b00);
    check("t1 idle ready", req_ready, 2'b00);
    tick(); #1;
    check("t1 c1 grant", grant, 2'b01);
    check("t1 c1 busy", busy, 1'b1);
    check("t1 c1 tx_valid", tx_valid, 1'b1);
    check("t1 c1 tx_data", tx_data, 8'h48);
    check("t1 c1 req_ready", req_ready, 2'b01);
    tick(); #1;
    check("t1 c2 tx_data", tx_data, 8'h49);
    tick(); #1;
    check("t1 c3 tx_data", tx_data, 8'h0A);
    tick(); #1;
    check("t1 c4 grant", grant, 2'b00);
    check("t1 c4 busy", busy, 1'b0);
    check("t1 c4 tx_valid", tx_valid, 1'b0);
    ex(t0+1, 2'b01, 8'h48); ex(t0+2, 2'b01, 8'h49); ex(t0+3, 2'b01, 8'h0A);
    check_log("t1 log");

    // Rotation from a fresh reset.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      q0.push_back(8'h41); q0.push_back(8'h0A);
      q1.push_back(8'h42); q1.push_back(8'h0A);
    end
    en0 = 1'b1; en1 = 1'b1; refresh();
    t0 = cyc; viol = 0;
    repeat (20) tick();
    ex(t0+1, 2'b01, 8'h41); ex(t0+2, 2'b01, 8'h0A);
    ex(t0+4, 2'b10, 8'h42); ex(t0+5, 2'b10, 8'h0A);
    ex(t0+7, 2'b01, 8'h41); ex(t0+8, 2'b01, 8'h0A);
    ex(t0+10, 2'b10, 8'h42); ex(t0+11, 2'b10, 8'h0A);
    check_log("t2 log");
    check("t2 gap grant", gh[t0+3], 2'b00);
    check("t2 nonowner ready", viol, 0);

    // Burst limit: req1 owns first, req0 waits.
    en0 = 1'b0;
    for (int b = 8'h31; b <= 8'h36; b++) q1.push_back(8'(b));
    en1 = 1'b1; refresh();
    t0 = cyc;
    tick();
    en0 = 1'b1; q0.push_back(8'h50); q0.push_back(8'h0A); refresh();
    repeat (25) tick();
    ex(t0+1, 2'b10, 8'h31); ex(t0+2, 2'b10, 8'h32);
    ex(t0+3, 2'b10, 8'h33); ex(t0+4, 2'b10, 8'h34);
    ex(t0+6, 2'b01, 8'h50); ex(t0+7, 2'b01, 8'h0A);
    ex(t0+9, 2'b10, 8'h35); ex(t0+10, 2'b10, 8'h36);
    check_log("t3 log");
    check("t3 release grant", gh[t0+5], 2'b00);
    check("t3 req0 grant", gh[t0+6], 2'b01);
    check("t3 stall hold", gh[t0+18], 2'b10);
    check("t3 stall release", gh[t0+19], 2'b00);

    // Backpressure for 100 cycles mid-burst.
    q0.push_back(8'h61); q0.push_back(8'h62); q0.push_back(8'h63); q0.push_back(8'h0A);
    tx_ready = 1'b1; refresh();
    t0 = cyc;
    tick(); #1;
    check("t4 c1 tx_data", tx_data, 8'h61);
    tick();
    tx_ready = 1'b0; refresh();
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (grant !== 2'b01 || tx_data !== 8'h62 || tx_valid !== 1'b1) errs++;
      tick();
    end
    check("t4 stable errors", errs, 0);
    tx_ready = 1'b1; refresh();
    #1;
    check("t4 resume tx_data", tx_data, 8'h62);
    repeat (4) tick();
    ex(t0+1, 2'b01, 8'h61); ex(t0+102, 2'b01, 8'h62);
    ex(t0+103, 2'b01, 8'h63); ex(t0+104, 2'b01, 8'h0A);
    check_log("t4 log");
    check("t4 last grant", gh[t0+104], 2'b01);
    check("t4 release grant", gh[t0+105], 2'b00);

    // Stall timeout: req0 sends one byte then goes quiet.
    q0.push_back(8'h41); refresh();
    t0 = cyc;
    tick();
    q1.push_back(8'h42); q1.push_back(8'h0A); refresh();
    repeat (15) tick();
    ex(t0+1, 2'b01, 8'h41); ex(t0+11, 2'b10, 8'h42); ex(t0+12, 2'b10, 8'h0A);
    check_log("t5 log");
    check("t5 hold grant", gh[t0+9], 2'b01);
    check("t5 idle grant", gh[t0+10], 2'b00);
    check("t5 req1 grant", gh[t0+11], 2'b10);

    // Asynchronous reset mid-burst.
    q0.push_back(8'h71); q0.push_back(8'h72); q0.push_back(8'h73); q0.push_back(8'h0A);
    refresh();
    t0 = cyc;
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 grant", grant, 2'b00);
    check("t6 busy", busy, 1'b0);
    check("t6 tx_valid", tx_valid, 1'b0);
    check("t6 req_ready", req_ready, 2'b00);
    check("t6 tx_data", tx_data, 8'h00);
    ex(t0+1, 2'b01, 8'h71);
    check_log("t6 log");
    q1.push_back(8'h42); q1.push_back(8'h0A); refresh();
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("t6 idle grant", grant, 2'b00);
    tick(); #1;
    check("t6 first grant", grant, 2'b01);
    check("t6 resume data", tx_data, 8'h72);
    repeat (20) tick();
    check("final nonowner ready", viol, 0);
    check("final busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
